// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded-instruction inputs, bypass producers and EX-side outputs.
// The driver of the ID and bypass signals uses master; id_ex_stage uses slave.
interface id_ex_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 5
);
   // Decoded instruction from ID
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [CTRL_W-1:0] id_alu_ctrl;
   logic [REG_AW-1:0] id_rs1_addr;
   logic [REG_AW-1:0] id_rs2_addr;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic              id_src1_pc;
   logic              id_src2_imm;
   logic [REG_AW-1:0] id_rd_addr;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;

   // Pipeline control
   logic              flush;
   logic              hold;

   // Bypass producers
   logic              exm_valid;
   logic              exm_reg_write;
   logic [REG_AW-1:0] exm_rd_addr;
   logic [XLEN-1:0]   exm_data;
   logic              wb_valid;
   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_rd_addr;
   logic [XLEN-1:0]   wb_data;

   // EX-side results
   logic              id_stall;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc;
   logic [REG_AW-1:0] ex_rd_addr;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [XLEN-1:0]   alu_in1;
   logic [XLEN-1:0]   alu_in2;
   logic [XLEN-1:0]   ex_store_data;

   modport master (
      output id_valid, id_pc, id_alu_ctrl, id_rs1_addr, id_rs2_addr,
             id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_imm,
             id_src1_pc, id_src2_imm, id_rd_addr, id_reg_write, id_mem_read,
             id_mem_write, flush, hold,
             exm_valid, exm_reg_write, exm_rd_addr, exm_data,
             wb_valid, wb_reg_write, wb_rd_addr, wb_data,
      input  id_stall, ex_valid, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read,
             ex_mem_write, alu_ctrl, alu_in1, alu_in2, ex_store_data
   );

   modport slave (
      input  id_valid, id_pc, id_alu_ctrl, id_rs1_addr, id_rs2_addr,
             id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_imm,
             id_src1_pc, id_src2_imm, id_rd_addr, id_reg_write, id_mem_read,
             id_mem_write, flush, hold,
             exm_valid, exm_reg_write, exm_rd_addr, exm_data,
             wb_valid, wb_reg_write, wb_rd_addr, wb_data,
      output id_stall, ex_valid, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read,
             ex_mem_write, alu_ctrl, alu_in1, alu_in2, ex_store_data
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush/hold control and
// two-level operand forwarding (EX/MEM over MEM/WB) feeding the EX ALU.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 5
) (
   input logic   clk,
   input logic   rst,
   id_ex_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [CTRL_W-1:0] alu_ctrl;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic              src1_pc;
      logic              src2_imm;
      logic [REG_AW-1:0] rd_addr;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
   } ex_reg_t;

   typedef enum logic [1:0] {
      UPD_LOAD,
      UPD_HOLD,
      UPD_BUBBLE
   } upd_e;

   ex_reg_t         ex_q;
   ex_reg_t         ex_d;
   upd_e            upd;
   logic            load_use;
   logic            wb_hit_id1;
   logic            wb_hit_id2;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // A producer only bypasses when it really writes a non-zero register.
   function automatic logic producer_hit(
      input logic              valid,
      input logic              reg_write,
      input logic [REG_AW-1:0] rd,
      input logic [REG_AW-1:0] rs
   );
      return valid && reg_write && (rd != '0) && (rd == rs);
   endfunction

   // Load in EX whose result a valid ID instruction actually reads.
   assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                     bus.id_valid &&
                     ((bus.id_rs1_used && (bus.id_rs1_addr == ex_q.rd_addr)) ||
                      (bus.id_rs2_used && (bus.id_rs2_addr == ex_q.rd_addr)));

   // A flushed ID instruction is discarded, so it must never stall.
   assign bus.id_stall = load_use && !bus.flush;

   assign wb_hit_id1 = producer_hit(bus.wb_valid, bus.wb_reg_write,
                                    bus.wb_rd_addr, bus.id_rs1_addr);
   assign wb_hit_id2 = producer_hit(bus.wb_valid, bus.wb_reg_write,
                                    bus.wb_rd_addr, bus.id_rs2_addr);

   always_comb begin
      upd = UPD_LOAD;
      if (bus.flush)     upd = UPD_BUBBLE;
      else if (bus.hold) upd = UPD_HOLD;
      else if (load_use) upd = UPD_BUBBLE;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ex_d = ex_q;
      case (upd)
         UPD_BUBBLE: begin
            ex_d.valid     = 1'b0;
            ex_d.alu_ctrl  = '0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.mem_write = 1'b0;
         end
         UPD_LOAD: begin
            ex_d.valid     = bus.id_valid;
            ex_d.pc        = bus.id_pc;
            ex_d.alu_ctrl  = bus.id_valid ? bus.id_alu_ctrl : '0;
            ex_d.rs1_addr  = bus.id_rs1_addr;
            ex_d.rs2_addr  = bus.id_rs2_addr;
            // WB writes the register file this same cycle; ID read the old value.
            ex_d.rs1_data  = wb_hit_id1 ? bus.wb_data : bus.id_rs1_data;
            ex_d.rs2_data  = wb_hit_id2 ? bus.wb_data : bus.id_rs2_data;
            ex_d.imm       = bus.id_imm;
            ex_d.src1_pc   = bus.id_src1_pc;
            ex_d.src2_imm  = bus.id_src2_imm;
            ex_d.rd_addr   = bus.id_rd_addr;
            ex_d.reg_write = bus.id_valid && bus.id_reg_write;
            ex_d.mem_read  = bus.id_valid && bus.id_mem_read;
            ex_d.mem_write = bus.id_valid && bus.id_mem_write;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   // The younger EX/MEM result wins over MEM/WB.
   always_comb begin
      fwd_rs1 = ex_q.rs1_data;
      if (producer_hit(bus.exm_valid, bus.exm_reg_write, bus.exm_rd_addr, ex_q.rs1_addr))
         fwd_rs1 = bus.exm_data;
      else if (producer_hit(bus.wb_valid, bus.wb_reg_write, bus.wb_rd_addr, ex_q.rs1_addr))
         fwd_rs1 = bus.wb_data;
   end

   always_comb begin
      fwd_rs2 = ex_q.rs2_data;
      if (producer_hit(bus.exm_valid, bus.exm_reg_write, bus.exm_rd_addr, ex_q.rs2_addr))
         fwd_rs2 = bus.exm_data;
      else if (producer_hit(bus.wb_valid, bus.wb_reg_write, bus.wb_rd_addr, ex_q.rs2_addr))
         fwd_rs2 = bus.wb_data;
   end

   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_pc         = ex_q.pc;
   assign bus.ex_rd_addr    = ex_q.rd_addr;
   assign bus.ex_reg_write  = ex_q.valid && ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.valid && ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.valid && ex_q.mem_write;
   assign bus.alu_ctrl      = ex_q.valid ? ex_q.alu_ctrl : '0;
   assign bus.alu_in1       = ex_q.src1_pc  ? ex_q.pc  : fwd_rs1;
   assign bus.alu_in2       = ex_q.src2_imm ? ex_q.imm : fwd_rs2;
   assign bus.ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued when an
// instruction is presented to ID and compared when it is visible in EX.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst;

   id_ex_if #(.XLEN(32), .REG_AW(5), .CTRL_W(5)) bus ();

   id_ex_stage #(.XLEN(32), .REG_AW(5), .CTRL_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        valid;
      logic        full;
      logic [31:0] pc;
      logic [4:0]  ctrl;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [31:0] store;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask

   task automatic push(input string tag, input logic valid, input logic full,
                       input logic [31:0] pc, input logic [4:0] ctrl, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [31:0] in1, input logic [31:0] in2, input logic [31:0] store);
      exp_t e;
      e.tag = tag; e.valid = valid; e.full = full; e.pc = pc; e.ctrl = ctrl; e.rd = rd;
      e.rw = rw; e.mr = mr; e.mw = mw; e.in1 = in1; e.in2 = in2; e.store = store;
      sb.push_back(e);
   endtask

   task automatic push_bubble(input string tag);
      push(tag, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic compare_head();
      exp_t e;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check({e.tag, ".valid"}, 32'(bus.ex_valid), 32'(e.valid));
      check({e.tag, ".alu_ctrl"}, 32'(bus.alu_ctrl), 32'(e.ctrl));
      check({e.tag, ".reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
      check({e.tag, ".mem_read"}, 32'(bus.ex_mem_read), 32'(e.mr));
      check({e.tag, ".mem_write"}, 32'(bus.ex_mem_write), 32'(e.mw));
      if (e.full) begin
         check({e.tag, ".pc"}, bus.ex_pc, e.pc);
         check({e.tag, ".rd"}, 32'(bus.ex_rd_addr), 32'(e.rd));
         check({e.tag, ".alu_in1"}, bus.alu_in1, e.in1);
         check({e.tag, ".alu_in2"}, bus.alu_in2, e.in2);
         check({e.tag, ".store"}, bus.ex_store_data, e.store);
      end
   endtask

   task automatic set_id(input logic valid, input logic [31:0] pc, input logic [4:0] ctrl,
                         input logic [4:0] rs1, input logic [31:0] d1, input logic u1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic u2,
                         input logic [31:0] imm, input logic s1pc, input logic s2imm,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
      bus.id_valid = valid;   bus.id_pc = pc;        bus.id_alu_ctrl = ctrl;
      bus.id_rs1_addr = rs1;  bus.id_rs1_data = d1;  bus.id_rs1_used = u1;
      bus.id_rs2_addr = rs2;  bus.id_rs2_data = d2;  bus.id_rs2_used = u2;
      bus.id_imm = imm;       bus.id_src1_pc = s1pc; bus.id_src2_imm = s2imm;
      bus.id_rd_addr = rd;    bus.id_reg_write = rw; bus.id_mem_read = mr;
      bus.id_mem_write = mw;
   endtask

   task automatic set_exm(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] d);
      bus.exm_valid = v; bus.exm_reg_write = rw; bus.exm_rd_addr = rd; bus.exm_data = d;
   endtask

   task automatic set_wb(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] d);
      bus.wb_valid = v; bus.wb_reg_write = rw; bus.wb_rd_addr = rd; bus.wb_data = d;
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.hold  = 1'b0;
      set_exm(0, 0, 5'd0, 32'h0);
      set_wb(0, 0, 5'd0, 32'h0);
      // add x3,x1,x2 presented during reset
      set_id(1, 32'h100, 5'd1, 5'd1, 32'd5, 1, 5'd2, 32'd7, 1, 32'h0, 0, 0, 5'd3, 1, 0, 0);
      tick();
      tick();
      #1;
      check("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
      check("rst.alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      check("rst.alu_in1", bus.alu_in1, 32'd0);
      check("rst.alu_in2", bus.alu_in2, 32'd0);
      check("rst.store", bus.ex_store_data, 32'd0);
      check("rst.id_stall", 32'(bus.id_stall), 32'd0);
      rst = 1'b0;
      push("add", 1, 1, 32'h100, 5'd1, 5'd3, 1, 0, 0, 32'd5, 32'd7, 32'd7);
      tick();

      // sub x4,x3,x1 with stale x3: EX/MEM forwards 12
      set_id(1, 32'h104, 5'd2, 5'd3, 32'd0, 1, 5'd1, 32'd5, 1, 32'h0, 0, 0, 5'd4, 1, 0, 0);
      push("sub_exm", 1, 1, 32'h104, 5'd2, 5'd4, 1, 0, 0, 32'd12, 32'd5, 32'd5);
      #1 compare_head();
      tick();

      // or x5,x3,x1: x3 now only in MEM/WB
      set_exm(1, 1, 5'd3, 32'd12);
      set_id(1, 32'h108, 5'd3, 5'd3, 32'd0, 1, 5'd1, 32'd5, 1, 32'h0, 0, 0, 5'd5, 1, 0, 0);
      push("or_wb", 1, 1, 32'h108, 5'd3, 5'd5, 1, 0, 0, 32'd12, 32'd5, 32'd5);
      #1 compare_head();
      tick();

      // and x6,x3,x1: both producers target x3, EX/MEM must win
      set_exm(1, 1, 5'd4, 32'd99);
      set_wb(1, 1, 5'd3, 32'd12);
      set_id(1, 32'h10C, 5'd4, 5'd3, 32'd0, 1, 5'd1, 32'd5, 1, 32'h0, 0, 0, 5'd6, 1, 0, 0);
      push("and_prio", 1, 1, 32'h10C, 5'd4, 5'd6, 1, 0, 0, 32'd20, 32'd5, 32'd5);
      #1 compare_head();
      tick();

      // lw x5,8(x1)
      set_exm(1, 1, 5'd3, 32'd20);
      set_wb(1, 1, 5'd3, 32'd12);
      set_id(1, 32'h110, 5'd1, 5'd1, 32'd100, 1, 5'd0, 32'd0, 0, 32'd8, 0, 1, 5'd5, 1, 1, 0);
      push("lw", 1, 1, 32'h110, 5'd1, 5'd5, 1, 1, 0, 32'd100, 32'd8, 32'd0);
      #1 compare_head();
      tick();

      // add x6,x5,x0 right behind the load: one stall cycle, one bubble
      set_exm(0, 0, 5'd0, 32'h0);
      set_wb(0, 0, 5'd0, 32'h0);
      set_id(1, 32'h114, 5'd1, 5'd5, 32'd0, 1, 5'd0, 32'd0, 1, 32'h0, 0, 0, 5'd6, 1, 0, 0);
      #1;
      check("stall_loaduse", 32'(bus.id_stall), 32'd1);
      push_bubble("bubble_lu");
      compare_head();
      tick();
      #1;
      check("stall_once", 32'(bus.id_stall), 32'd0);
      push("add_after_lu", 1, 1, 32'h114, 5'd1, 5'd6, 1, 0, 0, 32'h1234, 32'd0, 32'd0);
      compare_head();
      tick();

      // lw x0 then a consumer of x0: no stall, and x0 is never forwarded
      set_exm(1, 1, 5'd5, 32'h1234);
      set_id(1, 32'h118, 5'd1, 5'd1, 32'd100, 1, 5'd0, 32'd0, 0, 32'd0, 0, 1, 5'd0, 1, 1, 0);
      push("lw_x0", 1, 1, 32'h118, 5'd1, 5'd0, 1, 1, 0, 32'd100, 32'd0, 32'd0);
      #1 compare_head();
      tick();
      set_exm(0, 0, 5'd0, 32'h0);
      set_id(1, 32'h11C, 5'd2, 5'd0, 32'd0, 1, 5'd2, 32'd7, 1, 32'h0, 0, 0, 5'd8, 1, 0, 0);
      #1;
      check("stall_x0", 32'(bus.id_stall), 32'd0);
      push("x0_guard", 1, 1, 32'h11C, 5'd2, 5'd8, 1, 0, 0, 32'd0, 32'd7, 32'd7);
      compare_head();
      tick();

      // lw x5, then an immediate op naming x5 as an unused rs2: no stall
      set_exm(1, 1, 5'd0, 32'hDEADBEEF);
      set_id(1, 32'h120, 5'd1, 5'd1, 32'd100, 1, 5'd0, 32'd0, 0, 32'd0, 0, 1, 5'd5, 1, 1, 0);
      push("lw_x5b", 1, 1, 32'h120, 5'd1, 5'd5, 1, 1, 0, 32'd100, 32'd0, 32'd0);
      #1 compare_head();
      tick();
      set_exm(0, 0, 5'd0, 32'h0);
      set_id(1, 32'h124, 5'd6, 5'd1, 32'd5, 1, 5'd5, 32'd0, 0, 32'd4, 0, 1, 5'd9, 1, 0, 0);
      #1;
      check("stall_rs2_unused", 32'(bus.id_stall), 32'd0);
      push("imm_op", 1, 1, 32'h124, 5'd6, 5'd9, 1, 0, 0, 32'd5, 32'd4, 32'd0);
      compare_head();
      tick();

      // hold for 3 edges with a new instruction waiting in ID
      bus.hold = 1'b1;
      set_id(1, 32'h128, 5'd5, 5'd2, 32'd7, 1, 5'd1, 32'd5, 1, 32'h0, 0, 0, 5'd10, 1, 0, 0);
      #1 compare_head();
      for (int i = 0; i < 3; i++) begin
         push("hold", 1, 1, 32'h124, 5'd6, 5'd9, 1, 0, 0, 32'd5, 32'd4, 32'd0);
         tick();
         if (i == 2) bus.hold = 1'b0;
         #1 compare_head();
      end
      push("after_hold", 1, 1, 32'h128, 5'd5, 5'd10, 1, 0, 0, 32'd7, 32'd5, 32'd5);
      tick();

      // hold and flush together: flush wins
      bus.hold  = 1'b1;
      bus.flush = 1'b1;
      set_id(1, 32'h12C, 5'd3, 5'd1, 32'd5, 1, 5'd2, 32'd7, 1, 32'h0, 0, 0, 5'd11, 1, 0, 0);
      push_bubble("hold_flush");
      #1 compare_head();
      tick();

      // flush arriving during a load-use stall
      bus.hold  = 1'b0;
      bus.flush = 1'b0;
      set_id(1, 32'h130, 5'd1, 5'd1, 32'd100, 1, 5'd0, 32'd0, 0, 32'd0, 0, 1, 5'd5, 1, 1, 0);
      push("lw_pre_flush", 1, 1, 32'h130, 5'd1, 5'd5, 1, 1, 0, 32'd100, 32'd0, 32'd0);
      #1 compare_head();
      tick();
      set_id(1, 32'h134, 5'd1, 5'd5, 32'd0, 1, 5'd2, 32'd7, 1, 32'h0, 0, 0, 5'd6, 1, 0, 0);
      #1;
      check("stall_pre_flush", 32'(bus.id_stall), 32'd1);
      bus.flush = 1'b1;
      #1;
      check("stall_flush", 32'(bus.id_stall), 32'd0);
      push_bubble("flush_stall");
      compare_head();
      tick();

      // WB writes x7 in the same cycle ID reads it: captured value must be 0x55
      bus.flush = 1'b0;
      set_wb(1, 1, 5'd7, 32'h55);
      set_id(1, 32'h138, 5'd7, 5'd1, 32'd5, 1, 5'd7, 32'd0, 1, 32'h0, 0, 0, 5'd11, 0, 0, 1);
      push("wb_capture", 1, 1, 32'h138, 5'd7, 5'd11, 0, 0, 1, 32'd5, 32'h55, 32'h55);
      #1 compare_head();
      tick();

      // invalid ID slot: controls captured as zero
      set_wb(0, 0, 5'd0, 32'h0);
      set_id(0, 32'h13C, 5'd3, 5'd1, 32'd5, 1, 5'd2, 32'd7, 1, 32'h0, 0, 0, 5'd12, 1, 1, 1);
      push_bubble("id_invalid");
      #1 compare_head();
      tick();
      #1 compare_head();

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
